// File: rtl/pix_pkg.sv
// Shared {x,y,RGB} pixel-word definitions for the pixel-stream stages.
package pix_pkg;

  localparam int unsigned X_HI = 49;
  localparam int unsigned X_LO = 41;
  localparam int unsigned Y_HI = 40;
  localparam int unsigned Y_LO = 32;
  localparam int unsigned R_HI = 23;
  localparam int unsigned R_LO = 16;
  localparam int unsigned G_HI = 15;
  localparam int unsigned G_LO = 8;
  localparam int unsigned B_HI = 7;
  localparam int unsigned B_LO = 0;

  localparam int unsigned IMG_W   = 320;
  localparam int unsigned COORD_W = 9;
  localparam int unsigned WORD_W  = 64;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [13:0]        pad_hi;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [7:0]         pad_lo;
    rgb_t               rgb;
  } pix_word_t;

  typedef enum logic [1:0] {
    HB_EMPTY,
    HB_RUN,
    HB_FLUSH
  } hblur3_state_e;

  // Build a word with zeroed pad fields.
  function automatic pix_word_t pack_pix(input logic [COORD_W-1:0] x,
                                         input logic [COORD_W-1:0] y,
                                         input rgb_t rgb);
    logic [WORD_W-1:0] w;
    w = '0;
    w[X_HI:X_LO] = x;
    w[Y_HI:Y_LO] = y;
    w[R_HI:R_LO] = rgb.r;
    w[G_HI:G_LO] = rgb.g;
    w[B_HI:B_LO] = rgb.b;
    return pix_word_t'(w);
  endfunction

endpackage

// File: rtl/rgb_tap121.sv
// Per-channel 1-2-1 tap: (a + 2b + c) >> 2, truncated, on packed 24-bit RGB.
module rgb_tap121 (
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic [23:0] c,
  output logic [23:0] y
);

  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [9:0] sum;
    assign sum = 10'(a[8*i +: 8]) + {1'b0, b[8*i +: 8], 1'b0} + 10'(c[8*i +: 8]);
    assign y[8*i +: 8] = 8'(sum >> 2);
  end

endmodule

// File: rtl/hblur3.sv
// Horizontal 1-2-1 smoothing of the raster pixel stream with replicated row edges.
// Stream checking and the err flag are compiled in with HBLUR3_CHK_EN.
module hblur3
  import pix_pkg::*;
#(
  parameter int unsigned WIDTH = IMG_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data,
  input  logic        data_valid,
  output logic [63:0] data2,
  output logic        data_valid2,
  output logic        err
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);

  hblur3_state_e state_q, state_d;
  pix_word_t     prev_q, prev_d;
  pix_word_t     cur_q, cur_d;
  pix_word_t     data2_q, data2_d;
  logic          data_valid2_q, data_valid2_d;

  pix_word_t     p;
  logic          viol;
  logic          row_start;
  logic          advance;
  rgb_t          right_rgb;
  rgb_t          filt_rgb;

  assign p = pix_word_t'(data);

  // FLUSH replicates the last pixel as its own right neighbour.
  assign right_rgb = (state_q == HB_FLUSH) ? cur_q.rgb : p.rgb;

  rgb_tap121 u_tap (
    .a (prev_q.rgb),
    .b (cur_q.rgb),
    .c (right_rgb),
    .y (filt_rgb)
  );

  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    cur_d         = cur_q;
    data2_d       = data2_q;
    data_valid2_d = 1'b0;
    row_start     = 1'b0;
    advance       = 1'b0;

    unique case (state_q)
      HB_EMPTY: begin
        if (data_valid && !viol) row_start = 1'b1;
      end
      HB_RUN: begin
        if (data_valid) begin
          if (viol) begin
            state_d = HB_EMPTY;
            if (p.x == '0) row_start = 1'b1;
          end else begin
            advance       = 1'b1;
            data2_d       = pack_pix(cur_q.x, cur_q.y, filt_rgb);
            data_valid2_d = 1'b1;
            prev_d        = cur_q;
            cur_d         = p;
            state_d       = (p.x == X_LAST) ? HB_FLUSH : HB_RUN;
          end
        end
      end
      HB_FLUSH: begin
        state_d = HB_EMPTY;
        if (!viol) begin
          data2_d       = pack_pix(cur_q.x, cur_q.y, filt_rgb);
          data_valid2_d = 1'b1;
        end
      end
      default: state_d = HB_EMPTY;
    endcase

    // New row: the left neighbour of x=0 is the pixel itself.
    if (row_start) begin
      prev_d  = p;
      cur_d   = p;
      state_d = (WIDTH == 1) ? HB_FLUSH : HB_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HB_EMPTY;
      prev_q        <= '0;
      cur_q         <= '0;
      data2_q       <= '0;
      data_valid2_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      cur_q         <= cur_d;
      data2_q       <= data2_d;
      data_valid2_q <= data_valid2_d;
    end
  end

`ifdef HBLUR3_CHK_EN
  logic [COORD_W-1:0] exp_x_q, exp_x_d;
  logic [COORD_W-1:0] row_y_q, row_y_d;
  logic               err_q, err_d;

  always_comb begin
    viol = 1'b0;
    unique case (state_q)
      HB_EMPTY: viol = data_valid && (p.x != '0);
      HB_RUN:   viol = data_valid && ((p.x != exp_x_q) || (p.y != row_y_q));
      HB_FLUSH: viol = data_valid;
      default:  viol = 1'b0;
    endcase
  end

  always_comb begin
    exp_x_d = exp_x_q;
    row_y_d = row_y_q;
    err_d   = err_q | viol;
    if (row_start) begin
      exp_x_d = COORD_W'(1);
      row_y_d = p.y;
    end else if (advance) begin
      exp_x_d = p.x + COORD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_x_q <= '0;
      row_y_q <= '0;
      err_q   <= 1'b0;
    end else begin
      exp_x_q <= exp_x_d;
      row_y_q <= row_y_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  assign viol = 1'b0;
  assign err  = 1'b0;

  logic unused_nochk;
  assign unused_nochk = advance;
`endif

  assign data2       = data2_q;
  assign data_valid2 = data_valid2_q;

  logic unused_pad;
  assign unused_pad = ^{prev_q.pad_hi, prev_q.x, prev_q.y, prev_q.pad_lo,
                        cur_q.pad_hi, cur_q.pad_lo};

endmodule

// File: tb/tb_hblur3.sv
// Directed, table-driven bench for hblur3 (row filtering, latency, reset, stream checks).
module tb_hblur3;

  localparam int W = 320;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data;
  logic        data_valid;
  logic [63:0] data2;
  logic        data_valid2;
  logic        err;

  always #5 clk = ~clk;

  hblur3 dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .data_valid  (data_valid),
    .data2       (data2),
    .data_valid2 (data_valid2),
    .err         (err)
  );

  typedef struct {
    logic [63:0] w;
    int          cyc;
  } obs_t;

  typedef struct {
    int          x;
    logic [23:0] rgb;
  } vec_t;

  obs_t outq[$];
  int   accq[$];
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;

  // Record acceptance cycles and every output word with its cycle.
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    if (data_valid === 1'b1 && rst === 1'b0) accq.push_back(cyc);
    #1;
    if (data_valid2 === 1'b1) outq.push_back('{data2, cyc});
  end

  function automatic logic [63:0] mk(input int x, input int y, input logic [23:0] rgb);
    logic [8:0] xs;
    logic [8:0] ys;
    xs = 9'(x);
    ys = 9'(y);
    return {14'b0, xs, ys, 8'b0, rgb};
  endfunction

  function automatic logic [23:0] rgb_of(input int kind, input int x);
    case (kind)
      0:       return 24'h404040;
      1:       return {8'(x), 16'h0000};
      2:       return (x == 10) ? 24'h00FF00 : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic send_pix(input int x, input int y, input logic [23:0] rgb, input int gap);
    @(negedge clk);
    data       = mk(x, y, rgb);
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic send_row(input int y, input int kind, input int gap);
    for (int x = 0; x < W; x++) send_pix(x, y, rgb_of(kind, x), gap);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic clear_obs();
    outq.delete();
    accq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  vec_t ramp_tab[4];
  vec_t imp_tab[7];

  initial begin
    int bad;
    int nz;
    ramp_tab[0] = '{0,   24'h000000};
    ramp_tab[1] = '{5,   24'h050000};
    ramp_tab[2] = '{100, 24'h640000};
    ramp_tab[3] = '{319, 24'h3E0000};
    imp_tab[0]  = '{9,   24'h003F00};
    imp_tab[1]  = '{10,  24'h007F00};
    imp_tab[2]  = '{11,  24'h003F00};
    imp_tab[3]  = '{8,   24'h000000};
    imp_tab[4]  = '{12,  24'h000000};
    imp_tab[5]  = '{0,   24'h000000};
    imp_tab[6]  = '{319, 24'h000000};

    rst        = 1'b1;
    data       = '0;
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data2", data2, 64'h0);
    chk("reset_valid2", {63'b0, data_valid2}, 64'h0);
    chk("reset_err", {63'b0, err}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Flat row, one pixel every 4 cycles.
    clear_obs();
    send_row(3, 0, 4);
    settle();
    chk("flat_count", 64'(outq.size()), 64'(W));
    bad = 0;
    for (int i = 0; i < outq.size(); i++)
      if (outq[i].w !== mk(i, 3, 24'h404040)) bad++;
    chk("flat_words", 64'(bad), 64'h0);
    bad = 0;
    if (outq.size() == W && accq.size() == W) begin
      for (int i = 0; i < W - 1; i++)
        if (outq[i].cyc != accq[i+1]) bad++;
      if (outq[W-1].cyc != accq[W-1] + 1) bad++;
      if (outq[W-1].cyc != outq[W-2].cyc + 1) bad++;
    end else bad = 1;
    chk("flat_latency", 64'(bad), 64'h0);

    // Red ramp R=x.
    clear_obs();
    send_row(5, 1, 2);
    settle();
    chk("ramp_count", 64'(outq.size()), 64'(W));
    for (int i = 0; i < 4; i++) begin
      if (outq.size() > ramp_tab[i].x)
        chk($sformatf("ramp_x%0d", ramp_tab[i].x), outq[ramp_tab[i].x].w,
            mk(ramp_tab[i].x, 5, ramp_tab[i].rgb));
      else
        chk($sformatf("ramp_x%0d_missing", ramp_tab[i].x), 64'(outq.size()), 64'(W));
    end

    // Green impulse at x=10.
    clear_obs();
    send_row(7, 2, 2);
    settle();
    chk("imp_count", 64'(outq.size()), 64'(W));
    for (int i = 0; i < 7; i++) begin
      if (outq.size() > imp_tab[i].x)
        chk($sformatf("imp_x%0d", imp_tab[i].x), outq[imp_tab[i].x].w,
            mk(imp_tab[i].x, 7, imp_tab[i].rgb));
      else
        chk($sformatf("imp_x%0d_missing", imp_tab[i].x), 64'(outq.size()), 64'(W));
    end
    nz = 0;
    for (int i = 0; i < outq.size(); i++)
      if (outq[i].w[15:8] != 8'h00) nz++;
    chk("imp_nonzero_g", 64'(nz), 64'd3);

    // Two rows back to back at full rate.
    clear_obs();
    send_row(0, 0, 2);
    send_row(1, 0, 2);
    settle();
    chk("b2b_count", 64'(outq.size()), 64'(2 * W));
    if (outq.size() == 2 * W) begin
      chk("b2b_last_row0", outq[W-1].w, mk(W - 1, 0, 24'h404040));
      chk("b2b_first_row1", outq[W].w, mk(0, 1, 24'h404040));
      chk("b2b_order", 64'(outq[W].cyc > outq[W-1].cyc), 64'h1);
    end

    // Skipped x=7.
    clear_obs();
    for (int x = 0; x < 7; x++) send_pix(x, 9, 24'h101010, 2);
    chk("skip_err_before", {63'b0, err}, 64'h0);
    @(negedge clk);
    data       = mk(8, 9, 24'h101010);
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
`ifdef HBLUR3_CHK_EN
    chk("skip_err_set", {63'b0, err}, 64'h1);
    chk("skip_outputs", 64'(outq.size()), 64'd6);
    send_pix(9, 9, 24'h101010, 2);
    send_pix(10, 9, 24'h101010, 2);
    settle();
    chk("skip_no_more_out", 64'(outq.size()), 64'd6);
    send_pix(0, 10, 24'h202020, 2);
    send_pix(1, 10, 24'h202020, 2);
    @(negedge clk);
    chk("skip_restart_count", 64'(outq.size()), 64'd7);
    if (outq.size() == 7) chk("skip_restart_word", outq[6].w, mk(0, 10, 24'h202020));
    chk("skip_err_sticky", {63'b0, err}, 64'h1);
`else
    chk("skip_err_tied", {63'b0, err}, 64'h0);
    chk("skip_outputs", 64'(outq.size()), 64'd7);
`endif
    do_reset();
    chk("err_cleared", {63'b0, err}, 64'h0);

    // Reset while x=100 is held.
    clear_obs();
    for (int x = 0; x <= 100; x++) send_pix(x, 20, rgb_of(1, x), 2);
    chk("pre_rst_data2", data2, mk(99, 20, 24'h630000));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_data2", data2, 64'h0);
    chk("rst_valid2", {63'b0, data_valid2}, 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_obs();
    settle();
    chk("rst_no_flush", 64'(outq.size()), 64'h0);
    send_row(21, 1, 2);
    settle();
    chk("rst_row_count", 64'(outq.size()), 64'(W));
    if (outq.size() == W) begin
      chk("rst_row_first", outq[0].w, mk(0, 21, 24'h000000));
      chk("rst_row_last", outq[W-1].w, mk(W - 1, 21, 24'h3E0000));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
